// File: rtl/bridge_pwm_pkg.sv
// Shared types and constants for the bridge PWM gate generator.
// Imported by the top and the per-leg dead-time block.
package bridge_pwm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING,
      FAULT
   } state_e;

   localparam int MIN_PERIOD  = 4;
   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/bridge_leg_deadtime.sv
// One half-bridge leg: phase-shifted polarity, dead-time insertion
// and the registered complementary gate pair.
module bridge_leg_deadtime
   import bridge_pwm_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int DEAD_W = 8
) (
   input  logic              clk_160MHz,
   input  logic              rst_n,
   input  logic              run,
   input  logic [CNT_W-1:0]  cnt,
   input  logic [CNT_W-1:0]  period_q,
   input  logic [CNT_W-1:0]  phase_q,
   input  logic [DEAD_W-1:0] dead_q,
   output logic              gate_hi,
   output logic              gate_lo
);

   logic [CNT_W:0]  sum;
   logic [CNT_W:0]  pos;
   logic            pol;
   logic            pol_q;
   logic            run_q;
   logic [DEAD_W-1:0] dc_q;
   logic [DEAD_W-1:0] dc_d;
   logic            dc_zero;

   always_comb begin
      sum = {1'b0, cnt} + {1'b0, phase_q};
      pos = sum;
      if (sum >= {1'b0, period_q}) begin
         pos = sum - {1'b0, period_q};
      end
      pol = (pos < {2'b00, period_q[CNT_W-1:1]});
   end

   // Reload on any edge of pol, and on the first running cycle so the
   // very first conduction is also preceded by the dead time.
   always_comb begin
      dc_d = dc_q;
      if (!run_q || (pol != pol_q)) begin
         dc_d = dead_q;
      end else if (dc_q != '0) begin
         dc_d = dc_q - DEAD_W'(1);
      end
      dc_zero = (dc_d == '0);
   end

   always_ff @(posedge clk_160MHz or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         pol_q   <= 1'b0;
         dc_q    <= '0;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
      end else begin
         run_q   <= run;
         pol_q   <= pol;
         dc_q    <= dc_d;
         gate_hi <= run & pol & dc_zero;
         gate_lo <= run & ~pol & dc_zero;
      end
   end

endmodule

// File: rtl/bridge_pwm_gen.sv
// Multi-leg bridge gate generator: fault synchronizer, run/stop FSM,
// period counter and period-boundary shadow registers.
module bridge_pwm_gen
   import bridge_pwm_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int DEAD_W = 8,
   parameter int N_LEGS = 2
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    enable_i,
   input  logic [CNT_W-1:0]        period_i,
   input  logic [N_LEGS*CNT_W-1:0] phase_i,
   input  logic [DEAD_W-1:0]       dead_i,
   input  logic                    fault_i,
   input  logic                    fault_clr_i,
   output logic [N_LEGS-1:0]       gate_hi_o,
   output logic [N_LEGS-1:0]       gate_lo_o,
   output logic                    running_o,
   output logic                    fault_o,
   output logic                    wrap_o
);

   logic [SYNC_STAGES-1:0] fault_sync;
   logic                   fault_s;

   state_e state_q;
   state_e state_d;

   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  period_q;
   logic [CNT_W-1:0]  phase_q [N_LEGS];
   logic [DEAD_W-1:0] dead_q;

   logic [CNT_W-1:0]  period_ld;
   logic [CNT_W-1:0]  phase_ld [N_LEGS];

   logic running;
   logic wrap_hit;
   logic run_leg;
   logic load;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         fault_sync <= '0;
      end else begin
         fault_sync <= {fault_sync[SYNC_STAGES-2:0], fault_i};
      end
   end

   assign fault_s = fault_sync[SYNC_STAGES-1];

   assign running  = (state_q == RUN) || (state_q == STOPPING);
   assign wrap_hit = running && (cnt_q == period_q - CNT_W'(1));
   // Gates drop in the same update that enters FAULT.
   assign run_leg  = running && !fault_s;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (fault_s) begin
               state_d = FAULT;
            end else if (enable_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (fault_s) begin
               state_d = FAULT;
            end else if (!enable_i) begin
               state_d = STOPPING;
            end
         end
         STOPPING: begin
            if (fault_s) begin
               state_d = FAULT;
            end else if (enable_i) begin
               state_d = RUN;
            end else if (wrap_hit) begin
               state_d = IDLE;
            end
         end
         FAULT: begin
            if (fault_clr_i && !fault_s && !enable_i) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      cnt_d = '0;
      if (running && (state_d == RUN || state_d == STOPPING)) begin
         cnt_d = wrap_hit ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign load = (state_q == IDLE && state_d == RUN)
               || (wrap_hit && !fault_s);

   assign period_ld = (period_i < CNT_W'(MIN_PERIOD))
                    ? CNT_W'(MIN_PERIOD) : period_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wrap_o   <= 1'b0;
         period_q <= '0;
         dead_q   <= '0;
         for (int k = 0; k < N_LEGS; k++) begin
            phase_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_o  <= wrap_hit && !fault_s;
         if (load) begin
            period_q <= period_ld;
            dead_q   <= dead_i;
            for (int k = 0; k < N_LEGS; k++) begin
               phase_q[k] <= phase_ld[k];
            end
         end
      end
   end

   assign running_o = running;
   assign fault_o   = (state_q == FAULT);

   for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
      logic [CNT_W-1:0] slice;

      assign slice       = phase_i[k*CNT_W +: CNT_W];
      assign phase_ld[k] = (slice >= period_ld) ? '0 : slice;

      bridge_leg_deadtime #(
         .CNT_W  (CNT_W),
         .DEAD_W (DEAD_W)
      ) u_leg (
         .clk_160MHz (clk_i),
         .rst_n      (reset_ni),
         .run        (run_leg),
         .cnt        (cnt_q),
         .period_q   (period_q),
         .phase_q    (phase_q[k]),
         .dead_q     (dead_q),
         .gate_hi    (gate_hi_o[k]),
         .gate_lo    (gate_lo_o[k])
      );
   end

endmodule

// File: tb/tb_bridge_pwm_gen.sv
// Directed bench for bridge_pwm_gen with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bridge_pwm_gen;

   localparam int CNT_W  = 16;
   localparam int DEAD_W = 8;
   localparam int N_LEGS = 2;

   logic                    clk_i = 1'b0;
   logic                    reset_ni;
   logic                    enable_i;
   logic [CNT_W-1:0]        period_i;
   logic [N_LEGS*CNT_W-1:0] phase_i;
   logic [DEAD_W-1:0]       dead_i;
   logic                    fault_i;
   logic                    fault_clr_i;
   logic [N_LEGS-1:0]       gate_hi_o;
   logic [N_LEGS-1:0]       gate_lo_o;
   logic                    running_o;
   logic                    fault_o;
   logic                    wrap_o;

   int vectors     = 0;
   int miscompares = 0;
   int h0, l0, h1, l1, ov, wr, df, nb;

   always #3 clk_i = ~clk_i;

   bridge_pwm_gen #(
      .CNT_W  (CNT_W),
      .DEAD_W (DEAD_W),
      .N_LEGS (N_LEGS)
   ) dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .enable_i    (enable_i),
      .period_i    (period_i),
      .phase_i     (phase_i),
      .dead_i      (dead_i),
      .fault_i     (fault_i),
      .fault_clr_i (fault_clr_i),
      .gate_hi_o   (gate_hi_o),
      .gate_lo_o   (gate_lo_o),
      .running_o   (running_o),
      .fault_o     (fault_o),
      .wrap_o      (wrap_o)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tally(input int n);
      h0 = 0; l0 = 0; h1 = 0; l1 = 0;
      ov = 0; wr = 0; df = 0; nb = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         h0 += int'(gate_hi_o[0]);
         l0 += int'(gate_lo_o[0]);
         h1 += int'(gate_hi_o[1]);
         l1 += int'(gate_lo_o[1]);
         ov += int'(|(gate_hi_o & gate_lo_o));
         wr += int'(wrap_o);
         df += int'(gate_hi_o[0] != gate_hi_o[1]);
         nb += int'(gate_hi_o[0] == gate_lo_o[0]);
      end
   endtask

   function automatic int outs();
      return int'({gate_hi_o, gate_lo_o, running_o, fault_o, wrap_o});
   endfunction

   initial begin
      reset_ni    = 1'b1;
      enable_i    = 1'b0;
      period_i    = 16'd100;
      phase_i     = {16'd50, 16'd0};
      dead_i      = 8'd5;
      fault_i     = 1'b0;
      fault_clr_i = 1'b0;

      // reset and basic run
      #2 reset_ni = 1'b0;
      step(2);
      chk("reset_outs", outs(), 0);
      reset_ni = 1'b1;
      step(2);
      chk("idle_outs", outs(), 0);

      enable_i = 1'b1;
      step(1);
      chk("entry_running", int'(running_o), 1);
      chk("entry_no_wrap", int'(wrap_o), 0);
      step(5);
      chk("lead_in_dead", int'({gate_hi_o, gate_lo_o}), 0);
      step(1);
      chk("first_on", int'({gate_hi_o, gate_lo_o}), 'b0110);
      tally(94);
      chk("first_wrap_cnt", wr, 1);
      chk("first_wrap_o", int'(wrap_o), 1);

      tally(100);
      chk("p100_hi0", h0, 45);
      chk("p100_lo0", l0, 45);
      chk("p100_hi1", h1, 45);
      chk("p100_lo1", l1, 45);
      chk("p100_overlap", ov, 0);
      chk("p100_wraps", wr, 1);
      chk("p100_leg_inverse", df, 90);

      // period change mid-period
      step(30);
      period_i = 16'd200;
      tally(70);
      chk("old_period_hi0", h0, 20);
      chk("old_period_lo0", l0, 45);
      chk("old_period_wrap", wr, 1);
      period_i = 16'd100;
      tally(200);
      chk("p200_hi0", h0, 95);
      chk("p200_lo0", l0, 95);
      chk("p200_wraps", wr, 1);
      chk("p200_wrap_end", int'(wrap_o), 1);
      chk("p200_overlap", ov, 0);

      // graceful stop
      step(30);
      enable_i = 1'b0;
      step(1);
      chk("stopping_running", int'(running_o), 1);
      tally(69);
      chk("stop_hi0", h0, 19);
      chk("stop_lo0", l0, 45);
      chk("stop_wrap", wr, 1);
      chk("stop_idle", int'(running_o), 0);
      chk("stop_last_lo0", int'(gate_lo_o[0]), 1);
      step(1);
      chk("stop_gates_off", int'({gate_hi_o, gate_lo_o}), 0);

      // fault shutdown and clear handshake
      enable_i = 1'b1;
      step(1);
      step(20);
      fault_i = 1'b1;
      step(2);
      chk("pre_fault_gates", int'({gate_hi_o, gate_lo_o}), 'b0110);
      chk("pre_fault_flag", int'(fault_o), 0);
      step(1);
      chk("fault_gates", int'({gate_hi_o, gate_lo_o}), 0);
      chk("fault_flag", int'(fault_o), 1);
      chk("fault_not_run", int'(running_o), 0);
      fault_i = 1'b0;
      step(4);
      chk("fault_held", int'(fault_o), 1);
      fault_i = 1'b1;
      step(3);
      fault_clr_i = 1'b1;
      enable_i    = 1'b0;
      step(1);
      fault_clr_i = 1'b0;
      chk("clr_ignored_live", int'(fault_o), 1);
      fault_i = 1'b0;
      step(3);
      enable_i    = 1'b1;
      fault_clr_i = 1'b1;
      step(1);
      fault_clr_i = 1'b0;
      chk("clr_ignored_en", int'(fault_o), 1);
      enable_i    = 1'b0;
      fault_clr_i = 1'b1;
      step(1);
      fault_clr_i = 1'b0;
      chk("clr_to_idle", outs(), 0);

      // minimum period with zero dead time
      period_i = 16'd2;
      dead_i   = 8'd0;
      phase_i  = '0;
      enable_i = 1'b1;
      step(1);
      tally(8);
      chk("pmin_wraps", wr, 2);
      chk("pmin_hi0", h0, 4);
      chk("pmin_lo0", l0, 4);
      chk("pmin_complement", nb, 0);
      enable_i = 1'b0;
      step(6);
      chk("pmin_stopped", outs(), 0);

      // out-of-range phase clamps to 0
      period_i = 16'd100;
      phase_i  = {16'd0, 16'd150};
      enable_i = 1'b1;
      step(1);
      tally(100);
      chk("phase_clamp_df", df, 0);
      chk("phase_clamp_hi0", h0, 50);
      chk("dead0_complement", nb, 0);

      // dead time beyond half period keeps the leg off
      dead_i = 8'd60;
      tally(100);
      chk("dead_held_hi0", h0, 50);
      tally(100);
      chk("dead60_on", h0 + l0 + h1 + l1, 0);
      chk("dead60_wrap", wr, 1);

      // asynchronous reset mid-run
      dead_i = 8'd0;
      tally(100);
      step(10);
      chk("pre_reset_on", int'(gate_hi_o[0] | gate_lo_o[0]), 1);
      #1 reset_ni = 1'b0;
      #1;
      chk("async_reset", outs(), 0);
      enable_i = 1'b0;
      #1 reset_ni = 1'b1;
      step(2);
      chk("post_reset_idle", outs(), 0);

      // random sweep
      for (int it = 0; it < 12; it++) begin
         period_i = 16'($urandom_range(4, 60));
         dead_i   = 8'($urandom_range(0, 20));
         phase_i  = {16'($urandom_range(0, 80)),
                     16'($urandom_range(0, 80))};
         enable_i = 1'b1;
         for (int j = 0; j < 150; j++) begin
            step(1);
            chk("rand_overlap", int'(gate_hi_o & gate_lo_o), 0);
         end
         enable_i = 1'b0;
         step(70);
         chk("rand_stop", int'(running_o), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
